// File: rtl/aes_pkg.sv
// ============================================================================
//  Module   : aes_pkg
//  Purpose  : Shared constants, FSM state type and GF arithmetic helpers for
//             the AES-256 inverse key schedule. The composite-field S-box
//             basis-change matrices are derived at elaboration time from the
//             AES polynomial, so no hand-copied matrix can drift out of sync
//             with the GF(2^4) arithmetic used by the datapath.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

   localparam int NK = 8;
   localparam int NR = 14;

   // GF(2^8) is built as GF(2^4)[z]/(z^2 + z + LAMBDA), GF(2^4) = GF(2)[y]/(y^4+y+1).
   // LAMBDA = y^3 + y^2 has trace 1, so the quadratic is irreducible.
   localparam logic [3:0] GF16_LAMBDA = 4'hC;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_GEN  = 2'd2
   } state_t;

   function automatic logic [7:0] rcon(input logic [2:0] idx);
      logic [7:0] val;
      case (idx)
         3'd1:    val = 8'h01;
         3'd2:    val = 8'h02;
         3'd3:    val = 8'h04;
         3'd4:    val = 8'h08;
         3'd5:    val = 8'h10;
         3'd6:    val = 8'h20;
         3'd7:    val = 8'h40;
         default: val = 8'h00;
      endcase
      return val;
   endfunction

   function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] acc;
      logic [3:0] aa;
      acc = 4'h0;
      aa  = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) acc = acc ^ aa;
         aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
      end
      return acc;
   endfunction

   // a^-1 = a^14 = a^2 * a^4 * a^8; maps 0 to 0 as the S-box requires.
   function automatic logic [3:0] gf16_inv(input logic [3:0] a);
      logic [3:0] a2;
      logic [3:0] a4;
      logic [3:0] a8;
      a2 = gf16_mul(a, a);
      a4 = gf16_mul(a2, a2);
      a8 = gf16_mul(a4, a4);
      return gf16_mul(gf16_mul(a2, a4), a8);
   endfunction

   // Multiply in the AES field; used only while deriving the basis matrices.
   function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] aa;
      acc = 8'h00;
      aa  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
      end
      return acc;
   endfunction

   // Linear map over GF(2): column k of m (bits 8k+7:8k) is the image of bit k.
   function automatic logic [7:0] lin_map(input logic [63:0] m, input logic [7:0] v);
      logic [7:0] acc;
      acc = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (v[k]) acc = acc ^ m[8*k +: 8];
      end
      return acc;
   endfunction

   // Composite -> AES polynomial basis. A composite byte {h,l} stands for
   // h*beta + l where alpha (root of y^4+y+1) embeds GF(2^4) and beta is a
   // root of z^2 + z + LAMBDA in the AES field.
   function automatic logic [63:0] calc_c2p();
      logic [7:0]      alpha;
      logic [7:0]      beta;
      logic [7:0]      lam8;
      logic [7:0]      x;
      logic [7:0]      x2;
      logic            found_a;
      logic            found_b;
      logic [3:0][7:0] ap;
      logic [63:0]     m;
      alpha   = 8'h00;
      beta    = 8'h00;
      found_a = 1'b0;
      found_b = 1'b0;
      for (int a = 1; a < 256; a++) begin
         x  = 8'(a);
         x2 = gf8_mul(x, x);
         if (!found_a && ((gf8_mul(x2, x2) ^ x ^ 8'h01) == 8'h00)) begin
            alpha   = x;
            found_a = 1'b1;
         end
      end
      ap[0] = 8'h01;
      for (int i = 1; i < 4; i++) ap[i] = gf8_mul(ap[i-1], alpha);
      lam8 = 8'h00;
      for (int i = 0; i < 4; i++) begin
         if (GF16_LAMBDA[i]) lam8 = lam8 ^ ap[i];
      end
      for (int b = 0; b < 256; b++) begin
         x = 8'(b);
         if (!found_b && ((gf8_mul(x, x) ^ x ^ lam8) == 8'h00)) begin
            beta    = x;
            found_b = 1'b1;
         end
      end
      for (int i = 0; i < 4; i++) begin
         m[8*i +: 8]     = ap[i];
         m[8*(i+4) +: 8] = gf8_mul(ap[i], beta);
      end
      return m;
   endfunction

   // Inverse of a basis matrix by Gauss-Jordan elimination over GF(2).
   function automatic logic [63:0] calc_p2c(input logic [63:0] m);
      logic [7:0][7:0] c;
      logic [7:0][7:0] t;
      logic [7:0]      tmp;
      logic            got;
      logic [63:0]     r;
      for (int k = 0; k < 8; k++) begin
         c[k] = m[8*k +: 8];
         t[k] = 8'h01 << k;
      end
      for (int b = 0; b < 8; b++) begin
         got = 1'b0;
         for (int k = b; k < 8; k++) begin
            if (!got && c[k][b]) begin
               tmp  = c[b]; c[b] = c[k]; c[k] = tmp;
               tmp  = t[b]; t[b] = t[k]; t[k] = tmp;
               got  = 1'b1;
            end
         end
         for (int k = 0; k < 8; k++) begin
            if ((k != b) && c[k][b]) begin
               c[k] = c[k] ^ c[b];
               t[k] = t[k] ^ t[b];
            end
         end
      end
      for (int b = 0; b < 8; b++) r[8*b +: 8] = t[b];
      return r;
   endfunction

   localparam logic [63:0] C_C2P = calc_c2p();
   localparam logic [63:0] C_P2C = calc_p2c(C_C2P);

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
//  Module   : aes_sbox
//  Purpose  : Combinational AES forward S-box using GF((2^4)^2) inversion
//             followed by the AES affine transform.
//  Ports    : i_data [7:0]  byte to substitute
//             o_data [7:0]  substituted byte
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] i_data,
   output logic [7:0] o_data
);

   logic [7:0] w_comp;
   logic [3:0] w_hi;
   logic [3:0] w_lo;
   logic [3:0] w_delta;
   logic [3:0] w_dinv;
   logic [7:0] w_inv;

   always_comb begin
      w_comp  = lin_map(C_P2C, i_data);
      w_hi    = w_comp[7:4];
      w_lo    = w_comp[3:0];
      // (h z + l)^-1 = (h d) z + (h + l) d, with d = (h^2 LAMBDA + h l + l^2)^-1
      w_delta = gf16_mul(gf16_mul(w_hi, w_hi), GF16_LAMBDA)
              ^ gf16_mul(w_hi, w_lo) ^ gf16_mul(w_lo, w_lo);
      w_dinv  = gf16_inv(w_delta);
      w_inv   = lin_map(C_C2P, {gf16_mul(w_hi, w_dinv), gf16_mul(w_hi ^ w_lo, w_dinv)});
      o_data  = w_inv
              ^ {w_inv[6:0], w_inv[7]}
              ^ {w_inv[5:0], w_inv[7:6]}
              ^ {w_inv[4:0], w_inv[7:5]}
              ^ {w_inv[3:0], w_inv[7:4]}
              ^ 8'h63;
   end

endmodule

`default_nettype wire

// File: rtl/aes256_inv_key_sched.sv
// ============================================================================
//  Module   : aes256_inv_key_sched
//  Purpose  : Walks the AES-256 key schedule backwards from the last eight
//             words w[52..59], emitting round keys 14 down to 0 over a
//             valid/ready handshake.
//  Ports    : clk           rising-edge clock
//             rst           asynchronous active-high reset
//             start         load request, honoured in IDLE only
//             key_in [255:0] {w[52]..w[59]}, w[52] in the MSBs
//             rk_out [127:0] round key {w[4r]..w[4r+3]}
//             rk_round [3:0] round number r of rk_out
//             rk_valid      rk_out/rk_round valid
//             rk_ready      consumer accepts
//             busy          high outside IDLE
//             done          one-cycle pulse after the round-0 handshake
//  Options  : AES_INV_KS_ZEROIZE_EN - clear the key window when done pulses
//             and force rk_out to zero while rk_valid is low.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes256_inv_key_sched
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] key_in,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_round,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic         busy,
   output logic         done
);

   localparam logic [5:0] C_J_INIT     = 6'd52;
   localparam logic [3:0] C_ROUND_LAST = 4'(NR);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [0:NK-1][31:0] r_win;        // r_win[i] = w[j+i]
   logic [5:0]          r_j;
   logic [3:0]          r_round;
   logic                r_valid;
   logic                r_busy;
   logic                r_done;

   logic                w_load;
   logic                w_hs;
   logic                w_done_nxt;
   logic [5:0]          w_jm1;
   logic [2:0]          w_rc_idx;
   logic [31:0]         w_sub;
   logic [31:0]         w_t;
   logic [31:0]         w_new;
   logic [127:0]        w_rk_mux;

   // SubWord of win[6]; RotWord commutes with it, so rotation happens after.
   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
         .i_data (r_win[6][8*g +: 8]),
         .o_data (w_sub[8*g +: 8])
      );
   end

   always_comb begin
      w_jm1 = r_j - 6'd1;
      // (j+7)/8 equals ((j-1)/8)+1 whenever (j-1) mod 8 = 0
      w_rc_idx = w_jm1[5:3] + 3'd1;
      case (w_jm1[2:0])
         3'd0:    w_t = {w_sub[23:0], w_sub[31:24]} ^ {rcon(w_rc_idx), 24'h0};
         3'd4:    w_t = w_sub;
         default: w_t = r_win[6];
      endcase
      w_new = r_win[7] ^ w_t;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_hs        = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (rk_ready) begin
               w_hs = 1'b1;
               if (r_round == 4'd0) begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
               end else if (r_round == C_ROUND_LAST) begin
                  // Round 13 is already in win[0..3] after the load
                  w_state_nxt = ST_EMIT;
               end else begin
                  w_state_nxt = ST_GEN;
               end
            end
         end
         ST_GEN: begin
            // j enters GEN as a multiple of 4; the fourth word lands when j = 4m+1
            if (r_j[1:0] == 2'd1) w_state_nxt = ST_EMIT;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_win   <= '0;
         r_j     <= '0;
         r_round <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_valid <= (w_state_nxt == ST_EMIT);
         r_busy  <= (w_state_nxt != ST_IDLE);
         r_done  <= w_done_nxt;
         if (w_load) begin
            r_win   <= key_in;
            r_j     <= C_J_INIT;
            r_round <= C_ROUND_LAST;
         end else if (r_state == ST_GEN) begin
            r_win <= {w_new, r_win[0:NK-2]};
            r_j   <= w_jm1;
         end else if (w_hs && (r_round != 4'd0)) begin
            r_round <= r_round - 4'd1;
         end
`ifdef AES_INV_KS_ZEROIZE_EN
         if (w_done_nxt) r_win <= '0;
`endif
      end
   end

   // Round 14 is the upper half of the loaded window; all others the lower half.
   assign w_rk_mux = (r_round == C_ROUND_LAST) ? {r_win[4], r_win[5], r_win[6], r_win[7]}
                                               : {r_win[0], r_win[1], r_win[2], r_win[3]};

`ifdef AES_INV_KS_ZEROIZE_EN
   assign rk_out = r_valid ? w_rk_mux : 128'h0;
`else
   assign rk_out = w_rk_mux;
`endif

   assign rk_round = r_round;
   assign rk_valid = r_valid;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_aes256_inv_key_sched.sv
// ============================================================================
//  Module   : tb_aes256_inv_key_sched
//  Purpose  : Self-checking bench for aes256_inv_key_sched. A forward AES-256
//             key expansion model fills a scoreboard of expected round keys.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes256_inv_key_sched;

   typedef struct packed {
      logic [3:0]   rnd;
      logic [127:0] key;
   } exp_t;

   localparam logic [255:0] C_KEY0 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] C_KEY_LAST =
      256'h4e5a6699a9f24fe07e572baacdf8cdea_24fc79ccbf0979e9371ac23c6d68de36;

   logic         clk;
   logic         rst;
   logic         start;
   logic [255:0] key_in;
   logic [127:0] rk_out;
   logic [3:0]   rk_round;
   logic         rk_valid;
   logic         rk_ready;
   logic         busy;
   logic         done;

   int           n_checks;
   int           n_errors;
   exp_t         sbq[$];
   logic [7:0]   sb [256];
   logic [31:0]  mw [60];

   logic         prev_stall;
   logic [127:0] prev_out;
   logic [3:0]   prev_round;

   aes256_inv_key_sched dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key_in   (key_in),
      .rk_out   (rk_out),
      .rk_round (rk_round),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      end
      return p;
   endfunction

   // Brute-force inverse plus bitwise affine transform
   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] s;
      logic [7:0] c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         for (int i = 0; i < 8; i++) begin
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         end
         sb[x] = s;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   task automatic expand(input logic [255:0] k);
      logic [31:0] t;
      for (int i = 0; i < 8; i++) mw[i] = k[255-32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         t = mw[i-1];
         if (i % 8 == 0)      t = subw({t[23:0], t[31:24]}) ^ {(8'h01 << (i/8 - 1)), 24'h0};
         else if (i % 8 == 4) t = subw(t);
         mw[i] = mw[i-8] ^ t;
      end
   endtask

   task automatic push_run();
      exp_t e;
      for (int r = 14; r >= 0; r--) begin
         e.rnd = 4'(r);
         e.key = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
         sbq.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs until done is seen; optionally randomizes rk_ready (30% low).
   task automatic run_to_done(input string tag, input int budget, input bit rnd_ready,
                              output int cycles, output int busy_cycles);
      bit got;
      got = 1'b0;
      cycles = 0;
      busy_cycles = 0;
      while (!got && cycles < budget) begin
         tick();
         cycles++;
         start = 1'b0;
         if (busy) busy_cycles++;
         if (done) got = 1'b1;
         if (rnd_ready) rk_ready = ($urandom_range(0, 99) >= 30);
      end
      rk_ready = 1'b1;
      check({tag, "_done_seen"}, 256'(got), 256'(1));
   endtask

   // Scoreboard consumer: compare each handshake, and hold-stability while stalled
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (prev_stall && rk_valid) begin
            check("stall_rk_out", 256'(rk_out), 256'(prev_out));
            check("stall_rk_round", 256'(rk_round), 256'(prev_round));
         end
         if (rk_valid && rk_ready) begin
            n_checks++;
            assert (sbq.size() > 0) else begin
               n_errors++;
               $error("FAIL sb_pop: observed=handshake round %0d expected=no handshake", rk_round);
            end
            if (sbq.size() > 0) begin
               e = sbq.pop_front();
               check("rk_round", 256'(rk_round), 256'(e.rnd));
               check("rk_out", 256'(rk_out), 256'(e.key));
            end
         end
         prev_stall = rk_valid && !rk_ready;
         prev_out   = rk_out;
         prev_round = rk_round;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      int cyc;
      int bcyc;
      int k;
      logic [255:0] key_r;

      n_checks   = 0;
      n_errors   = 0;
      prev_stall = 1'b0;
      prev_out   = '0;
      prev_round = '0;
      rst        = 1'b1;
      start      = 1'b0;
      rk_ready   = 1'b1;
      key_in     = '0;
      build_sbox();

      // Reset state
      tick(); tick();
      check("rst_rk_valid", 256'(rk_valid), 256'(0));
      check("rst_busy", 256'(busy), 256'(0));
      check("rst_done", 256'(done), 256'(0));
      check("rst_rk_round", 256'(rk_round), 256'(0));
      check("rst_rk_out", 256'(rk_out), 256'(0));
      rst = 1'b0;
      tick();

      // FIPS-197 C.3 run, rk_ready tied high, timing checked
      expand(C_KEY0);
      push_run();
      key_in = C_KEY_LAST;
      start  = 1'b1;
      run_to_done("c3", 200, 1'b0, cyc, bcyc);
      check("c3_done_cycle", 256'(cyc), 256'(68));
      check("c3_busy_cycles", 256'(bcyc), 256'(67));
      check("c3_sb_empty", 256'(sbq.size()), 256'(0));
      tick();
      check("c3_done_pulse", 256'(done), 256'(0));
      check("c3_idle_valid", 256'(rk_valid), 256'(0));
`ifdef AES_INV_KS_ZEROIZE_EN
      check("zeroize_win", 256'(dut.r_win), 256'(0));
      check("zeroize_rk_out", 256'(rk_out), 256'(0));
`else
      check("retain_win", 256'(dut.r_win), C_KEY0);
`endif

      // Random key, random backpressure
      for (int i = 0; i < 8; i++) key_r[255-32*i -: 32] = $urandom();
      expand(key_r);
      for (int i = 0; i < 8; i++) key_in[255-32*i -: 32] = mw[52+i];
      push_run();
      tick();
      start = 1'b1;
      run_to_done("bp", 2000, 1'b1, cyc, bcyc);
      check("bp_sb_empty", 256'(sbq.size()), 256'(0));

      // start during EMIT of round 9 is ignored
      expand(C_KEY0);
      key_in = C_KEY_LAST;
      push_run();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (!(rk_valid && rk_round == 4'd9) && k < 200) begin
         tick();
         k++;
      end
      check("r9_reached", 256'(rk_valid && rk_round == 4'd9), 256'(1));
      key_in = ~C_KEY_LAST;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      run_to_done("r9", 200, 1'b0, cyc, bcyc);
      check("r9_sb_empty", 256'(sbq.size()), 256'(0));
      key_in = C_KEY_LAST;

      // Reset during GEN of round 7, then restart
      push_run();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (!(busy && !rk_valid && rk_round == 4'd7) && k < 200) begin
         tick();
         k++;
      end
      check("gen7_reached", 256'(busy && !rk_valid && rk_round == 4'd7), 256'(1));
      rst = 1'b1;
      sbq.delete();
      tick();
      check("mid_rst_rk_valid", 256'(rk_valid), 256'(0));
      check("mid_rst_busy", 256'(busy), 256'(0));
      check("mid_rst_done", 256'(done), 256'(0));
      check("mid_rst_rk_round", 256'(rk_round), 256'(0));
      check("mid_rst_rk_out", 256'(rk_out), 256'(0));
      rst = 1'b0;
      tick(); tick(); tick();
      check("post_rst_idle", 256'(busy), 256'(0));
      push_run();
      start = 1'b1;
      run_to_done("restart", 200, 1'b0, cyc, bcyc);
      check("restart_done_cycle", 256'(cyc), 256'(68));
      check("restart_sb_empty", 256'(sbq.size()), 256'(0));
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
